// File: rtl/regtracker_pkg.sv
// Shared CPU constants for the register scoreboard: register-file geometry,
// the hard-wired zero register index and the per-operand hazard test.
package regtracker_pkg;

  localparam int unsigned CPU_NUM_REGS = 32;
  localparam int unsigned CPU_REG_AW   = 5;
  localparam int unsigned REG_X0       = 0;

  // An operand is blocked when it is used, names a real register, that register
  // has a write in flight, and that write is not retiring this very cycle.
  function automatic logic operand_blocked(
    input logic valid,
    input logic idx_nonzero,
    input logic pend,
    input logic bypass
  );
    logic blk;
    if (valid && idx_nonzero && pend && !bypass) begin
      blk = 1'b1;
    end else begin
      blk = 1'b0;
    end
    return blk;
  endfunction

endpackage

// File: rtl/regtracker.sv
// Register scoreboard: tracks destinations issued from decode but not yet
// written back, raises a combinational stall on RAW/WAW hazards, and reserves
// the destination of every instruction that actually leaves decode.
module regtracker
  import regtracker_pkg::*;
#(
  parameter int unsigned NUM_REGS = CPU_NUM_REGS,
  parameter int unsigned REG_AW   = CPU_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rs1v,
  input  logic              rs2v,
  input  logic              rdv,
  input  logic              we,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [REG_AW-1:0] rd,
  input  logic [REG_AW-1:0] rdwbs,
  input  logic              jmp,
  input  logic              stall_jmp_mem,
  output logic              stall
);

  localparam logic [REG_AW-1:0] X0_IDX = REG_AW'(REG_X0);

  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_pending_next;
  logic                w_rs1_blk;
  logic                w_rs2_blk;
  logic                w_rd_blk;
  logic                w_issue;
  logic                w_wb_valid;

  // Per-operand hazard detection; invalid operands never look at their index.
  always_comb begin
    w_rs1_blk = 1'b0;
    w_rs2_blk = 1'b0;
    w_rd_blk  = 1'b0;
    if (rs1v) begin
      w_rs1_blk = operand_blocked(1'b1, rs1 != X0_IDX, r_pending[rs1],
                                  we && (rdwbs == rs1));
    end else begin
      w_rs1_blk = 1'b0;
    end
    if (rs2v) begin
      w_rs2_blk = operand_blocked(1'b1, rs2 != X0_IDX, r_pending[rs2],
                                  we && (rdwbs == rs2));
    end else begin
      w_rs2_blk = 1'b0;
    end
    if (rdv) begin
      w_rd_blk = operand_blocked(1'b1, rd != X0_IDX, r_pending[rd],
                                 we && (rdwbs == rd));
    end else begin
      w_rd_blk = 1'b0;
    end
  end

  assign stall = w_rs1_blk | w_rs2_blk | w_rd_blk;

  // Decide whether decode's destination is reserved and whether writeback frees one.
  always_comb begin
    w_issue    = 1'b0;
    w_wb_valid = 1'b0;
    if (rdv && (rd != X0_IDX) && !stall && !jmp && !stall_jmp_mem) begin
      w_issue = 1'b1;
    end else begin
      w_issue = 1'b0;
    end
    if (we && (rdwbs != X0_IDX)) begin
      w_wb_valid = 1'b1;
    end else begin
      w_wb_valid = 1'b0;
    end
  end

  // Per-register set/clear cell: x0 is tied off, a reservation beats a
  // same-cycle writeback to the same register.
  assign w_pending_next[0] = 1'b0;
  for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_cell
    logic w_set;
    logic w_clr;
    assign w_set = w_issue && (rd == REG_AW'(gi));
    assign w_clr = w_wb_valid && (rdwbs == REG_AW'(gi));
    assign w_pending_next[gi] = w_set | (r_pending[gi] & ~w_clr);
  end

  // Pending vector register; async reset drops every outstanding reservation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_next;
    end
  end

endmodule

// File: tb/tb_regtracker.sv
// Directed self-checking bench for the register scoreboard.
module tb_regtracker;

  logic       clk;
  logic       rst;
  logic       rs1v;
  logic       rs2v;
  logic       rdv;
  logic       we;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;
  logic [4:0] rdwbs;
  logic       jmp;
  logic       stall_jmp_mem;
  logic       stall;

  int n_checks;
  int n_fail;

  regtracker dut (
    .clk           (clk),
    .rst           (rst),
    .rs1v          (rs1v),
    .rs2v          (rs2v),
    .rdv           (rdv),
    .we            (we),
    .rs1           (rs1),
    .rs2           (rs2),
    .rd            (rd),
    .rdwbs         (rdwbs),
    .jmp           (jmp),
    .stall_jmp_mem (stall_jmp_mem),
    .stall         (stall)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    rs1v = 1'b0; rs2v = 1'b0; rdv = 1'b0; we = 1'b0;
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; rdwbs = 5'd0;
    jmp = 1'b0; stall_jmp_mem = 1'b0;
  endtask

  // Advance one rising edge; inputs change 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    #12;
    rs1v = 1'b1; rs1 = 5'd7;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall: got %b want 0", stall);
    end
    n_checks++;
    if (dut.r_pending !== 32'h0000_0000) begin
      n_fail++; $display("FAIL reset_pending: got %h want 00000000", dut.r_pending);
    end
    idle();
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_issue_bypass();
    rd = 5'd7; rdv = 1'b1; rs1 = 5'd4; rs1v = 1'b1; rs2 = 5'd2; rs2v = 1'b1;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL issue7_stall: got %b want 0", stall);
    end
    step();
    idle();
    #1;
    n_checks++;
    if (dut.r_pending !== 32'h0000_0080) begin
      n_fail++; $display("FAIL issue7_pending: got %h want 00000080", dut.r_pending);
    end
    rs1 = 5'd7; rs1v = 1'b1;
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++; $display("FAIL raw7_stall: got %b want 1", stall);
    end
    we = 1'b1; rdwbs = 5'd7;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL raw7_bypass: got %b want 0", stall);
    end
    step();
    idle();
    #1;
    n_checks++;
    if (dut.r_pending !== 32'h0000_0000) begin
      n_fail++; $display("FAIL wb7_pending: got %h want 00000000", dut.r_pending);
    end
  endtask

  task automatic test_squash();
    rd = 5'd6; rdv = 1'b1; jmp = 1'b1;
    step();
    idle();
    rs2 = 5'd6; rs2v = 1'b1;
    #1;
    n_checks++;
    if (stall !== 1'b0 || dut.r_pending !== 32'h0000_0000) begin
      n_fail++; $display("FAIL jmp_noreserve: got stall %b pend %h want 0 00000000", stall, dut.r_pending);
    end
    idle();
    rd = 5'd6; rdv = 1'b1; stall_jmp_mem = 1'b1;
    step();
    idle();
    rs2 = 5'd6; rs2v = 1'b1;
    #1;
    n_checks++;
    if (stall !== 1'b0 || dut.r_pending !== 32'h0000_0000) begin
      n_fail++; $display("FAIL smem_noreserve: got stall %b pend %h want 0 00000000", stall, dut.r_pending);
    end
    // stall itself ignores the squash inputs
    idle();
    rd = 5'd5; rdv = 1'b1;
    step();
    idle();
    rs1 = 5'd5; rs1v = 1'b1; jmp = 1'b1; stall_jmp_mem = 1'b1;
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++; $display("FAIL stall_ignores_jmp: got %b want 1", stall);
    end
    idle();
    we = 1'b1; rdwbs = 5'd5;
    step();
    idle();
  endtask

  task automatic test_waw();
    rd = 5'd23; rdv = 1'b1;
    step();
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++; $display("FAIL waw23_stall: got %b want 1", stall);
    end
    step();
    n_checks++;
    if (stall !== 1'b1 || dut.r_pending !== 32'h0080_0000) begin
      n_fail++; $display("FAIL waw23_hold: got stall %b pend %h want 1 00800000", stall, dut.r_pending);
    end
    we = 1'b1; rdwbs = 5'd23;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL waw23_release: got %b want 0", stall);
    end
    step();
    idle();
    #1;
    n_checks++;
    if (dut.r_pending !== 32'h0080_0000) begin
      n_fail++; $display("FAIL set_wins23: got %h want 00800000", dut.r_pending);
    end
    we = 1'b1; rdwbs = 5'd23;
    step();
    idle();
  endtask

  task automatic test_x0();
    for (int k = 0; k < 3; k++) begin
      rs1 = 5'd0; rs1v = 1'b1; rd = 5'd0; rdv = 1'b1; we = 1'b1; rdwbs = 5'd0;
      #1;
      n_checks++;
      if (stall !== 1'b0) begin
        n_fail++; $display("FAIL x0_stall[%0d]: got %b want 0", k, stall);
      end
      step();
      n_checks++;
      if (dut.r_pending !== 32'h0000_0000) begin
        n_fail++; $display("FAIL x0_pending[%0d]: got %h want 00000000", k, dut.r_pending);
      end
    end
    idle();
  endtask

  task automatic test_back_to_back();
    rd = 5'd3; rdv = 1'b1;
    step();
    idle();
    rd = 5'd9; rdv = 1'b1; we = 1'b1; rdwbs = 5'd3;
    step();
    idle();
    we = 1'b1; rdwbs = 5'd12;
    step();
    idle();
    #1;
    n_checks++;
    if (dut.r_pending !== 32'h0000_0200) begin
      n_fail++; $display("FAIL b2b_pending: got %h want 00000200", dut.r_pending);
    end
    rs1 = 5'd4; rs1v = 1'b1; rs2 = 5'd9; rs2v = 1'b1;
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++; $display("FAIL rs2_raw9: got %b want 1", stall);
    end
    idle();
    rs1 = 5'bxxxxx; rs2 = 5'bxxxxx; rd = 5'bxxxxx;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL invalid_ignored: got %b want 0", stall);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    rd = 5'd14; rdv = 1'b1;
    step();
    idle();
    #2;
    rst = 1'b0;
    #1;
    rs1 = 5'd9; rs1v = 1'b1;
    #1;
    n_checks++;
    if (stall !== 1'b0 || dut.r_pending !== 32'h0000_0000) begin
      n_fail++; $display("FAIL mid_reset: got stall %b pend %h want 0 00000000", stall, dut.r_pending);
    end
    idle();
    @(negedge clk);
    rst = 1'b1;
    rd = 5'd9; rdv = 1'b1; rs1 = 5'd14; rs1v = 1'b1;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_stall: got %b want 0", stall);
    end
    step();
    idle();
    #1;
    n_checks++;
    if (dut.r_pending !== 32'h0000_0200) begin
      n_fail++; $display("FAIL post_reset_pending: got %h want 00000200", dut.r_pending);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle();
    rst = 1'b0;
    test_reset();
    test_issue_bypass();
    test_squash();
    test_waw();
    test_x0();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
